// File: rtl/blk_b026cd_if.sv
// Fetch-stage bundle: stall/branch inputs, decode-side bus and instruction SRAM port.
// The master side is the fetch block.
interface blk_b026cd_if #(
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic [32:0]        br_bus;
    logic [32:0]        if_to_id_bus;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;

    modport master (
        input  stall, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/blk_b026cd.sv
// Instruction fetch: PC register, branch redirect with stall-time pending target.
// Latency 1 cycle PC->SRAM->decode; stall[0] freezes PC and holds the SRAM address.
// No stall output of its own: a branch seen during a stall is parked until release.
module blk_b026cd #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic          clk,
    input  logic          rst,
    blk_b026cd_if.master  bus
);
    localparam logic STOP = 1'b1;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_pc;
    logic        unused_stall;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign stall_pc     = bus.stall[0];
    assign unused_stall = ^bus.stall[$bits(bus.stall)-1:1];

    // Inputs are ignored in reset so the SRAM address settles on the first fetch.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (rst) begin
            if (stall_pc == STOP) begin
                next_pc = pc_r;
            end else if (br_e) begin
                next_pc = br_addr;
            end else if (pend_v) begin
                next_pc = pend_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= RESET_PC;
            ce_r      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
        end else if (stall_pc != STOP) begin
            pc_r   <= next_pc;
            ce_r   <= 1'b1;
            pend_v <= 1'b0;
        end else if (br_e) begin
            // Latest branch during a stall wins.
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end
    end

    assign bus.if_to_id_bus    = {ce_r, pc_r};
    assign bus.inst_sram_en    = rst;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = next_pc;
    assign bus.inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_blk_b026cd.sv
// Directed bench for the fetch stage with a cycle model and literal pins.
module tb_blk_b026cd;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   check_en;

    blk_b026cd_if ifc ();

    blk_b026cd dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the fetch stage must hold, from the rules.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pa;

    function automatic logic [31:0] m_next();
        if (!rst)                 return m_pc + 32'd4;
        if (ifc.stall[0])         return m_pc;
        if (ifc.br_bus[32])       return ifc.br_bus[31:0];
        if (m_pv)                 return m_pa;
        return m_pc + 32'd4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc <= 32'hBFBF_FFFC;
            m_ce <= 1'b0;
            m_pv <= 1'b0;
            m_pa <= 32'h0;
        end else if (!ifc.stall[0]) begin
            m_pc <= m_next();
            m_ce <= 1'b1;
            m_pv <= 1'b0;
        end else if (ifc.br_bus[32]) begin
            m_pv <= 1'b1;
            m_pa <= ifc.br_bus[31:0];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("mdl_bus",  64'(ifc.if_to_id_bus),   64'({m_ce, m_pc}));
            check("mdl_addr", 64'(ifc.inst_sram_addr), 64'(m_next()));
            check("mdl_en",   64'(ifc.inst_sram_en),   64'(rst));
            check("mdl_wen",  64'(ifc.inst_sram_wen),  64'(0));
            check("mdl_wdat", 64'(ifc.inst_sram_wdata), 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] pc, input logic [31:0] addr);
        check({name, "_pc"},   64'(ifc.if_to_id_bus), 64'({1'b1, pc}));
        check({name, "_addr"}, 64'(ifc.inst_sram_addr), 64'(addr));
    endtask

    task automatic br(input logic e, input logic [31:0] a);
        ifc.br_bus = {e, a};
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        check_en     = 1'b0;
        rst          = 1'b0;
        ifc.stall    = '0;
        ifc.br_bus   = '0;
        step();
        check_en = 1'b1;
        step();
        check("rst_bus", 64'(ifc.if_to_id_bus), 64'(33'h0_BFBF_FFFC));
        check("rst_en",  64'(ifc.inst_sram_en), 64'(0));
        rst = 1'b1;

        // Sequential fetch after reset release.
        step(); pin("seq0", 32'hBFC0_0000, 32'hBFC0_0004);
        step(); pin("seq1", 32'hBFC0_0004, 32'hBFC0_0008);
        step(); pin("seq2", 32'hBFC0_0008, 32'hBFC0_000C);
        step(); pin("seq3", 32'hBFC0_000C, 32'hBFC0_0010);
        step(); pin("seq4", 32'hBFC0_0010, 32'hBFC0_0014);

        // Plain stall for three cycles.
        ifc.stall[0] = 1'b1;
        #1 pin("stl_in", 32'hBFC0_0010, 32'hBFC0_0010);
        for (int i = 0; i < 3; i++) begin
            step(); pin("stl_hold", 32'hBFC0_0010, 32'hBFC0_0010);
        end
        ifc.stall[0] = 1'b0;
        #1 pin("stl_rel", 32'hBFC0_0010, 32'hBFC0_0014);
        step(); pin("stl_out", 32'hBFC0_0014, 32'hBFC0_0018);

        // Branch parked during a stall.
        ifc.stall[0] = 1'b1; br(1'b1, 32'h8000_0040);
        step(); br(1'b0, 32'h0);
        #1 pin("pnd_hold", 32'hBFC0_0014, 32'hBFC0_0014);
        step(); ifc.stall[0] = 1'b0;
        #1 pin("pnd_rel", 32'hBFC0_0014, 32'h8000_0040);
        step(); pin("pnd_out", 32'h8000_0040, 32'h8000_0044);

        // Second branch in the same stall overwrites the first.
        ifc.stall[0] = 1'b1; br(1'b1, 32'h8000_0040);
        step(); br(1'b1, 32'h8000_0080);
        step(); br(1'b0, 32'h0);
        step(); ifc.stall[0] = 1'b0;
        step(); pin("ovw_out", 32'h8000_0080, 32'h8000_0084);

        // Live branch on the release edge beats the parked one.
        ifc.stall[0] = 1'b1; br(1'b1, 32'h8000_0040);
        step(); br(1'b0, 32'h0);
        step(); ifc.stall[0] = 1'b0; br(1'b1, 32'h9000_0000);
        #1 pin("live_rel", 32'h8000_0080, 32'h9000_0000);
        step(); br(1'b0, 32'h0);
        #1 pin("live_out", 32'h9000_0000, 32'h9000_0004);

        // Asynchronous reset mid-cycle with a parked branch.
        ifc.stall[0] = 1'b1; br(1'b1, 32'h8000_0040);
        step();
        #2 rst = 1'b0;
        #1 check("arst_bus", 64'(ifc.if_to_id_bus), 64'(33'h0_BFBF_FFFC));
        check("arst_en",   64'(ifc.inst_sram_en),   64'(0));
        check("arst_addr", 64'(ifc.inst_sram_addr), 64'(32'hBFC0_0000));
        step(); step();
        check("arst_hold", 64'(ifc.if_to_id_bus), 64'(33'h0_BFBF_FFFC));
        ifc.stall[0] = 1'b0; br(1'b0, 32'h0);
        rst = 1'b1;
        step(); pin("rr0", 32'hBFC0_0000, 32'hBFC0_0004);
        step(); pin("rr1", 32'hBFC0_0004, 32'hBFC0_0008);
        step(); br(1'b1, 32'hBFC0_0100);
        #1 pin("br_at8", 32'hBFC0_0008, 32'hBFC0_0100);
        step(); br(1'b0, 32'h0);
        #1 pin("br_tgt", 32'hBFC0_0100, 32'hBFC0_0104);
        step(); pin("br_seq", 32'hBFC0_0104, 32'hBFC0_0108);

        // Address wrap and misaligned target.
        br(1'b1, 32'hFFFF_FFFC);
        step(); br(1'b0, 32'h0);
        #1 pin("wrap0", 32'hFFFF_FFFC, 32'h0000_0000);
        step(); pin("wrap1", 32'h0000_0000, 32'h0000_0004);
        br(1'b1, 32'h0000_0003);
        step(); br(1'b0, 32'h0);
        #1 pin("mis0", 32'h0000_0003, 32'h0000_0007);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
